// File: rtl/disp_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_fetch_if : control, AXI4 read-channel and status bundle of the        |
// |                 display frame fetch engine                                  |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
interface disp_fetch_if #(
   parameter int ADDR_W = 32
);
   logic              DISPON;
   logic              FSTART;
   logic [ADDR_W-1:0] DISPADDR;
   logic [15:0]       STRIDE;
   logic [9:0]        FIFO_LEVEL;
   logic [ADDR_W-1:0] ARADDR;
   logic [7:0]        ARLEN;
   logic              ARVALID;
   logic              ARREADY;
   logic              RVALID;
   logic              RLAST;
   logic [1:0]        RRESP;
   logic              RREADY;
   logic              BUSY;
   logic              DONE;
   logic              RD_ERR;

   modport master (
      input  DISPON, FSTART, DISPADDR, STRIDE, FIFO_LEVEL,
      input  ARREADY, RVALID, RLAST, RRESP,
      output ARADDR, ARLEN, ARVALID, RREADY, BUSY, DONE, RD_ERR
   );

   modport slave (
      output DISPON, FSTART, DISPADDR, STRIDE, FIFO_LEVEL,
      output ARREADY, RVALID, RLAST, RRESP,
      input  ARADDR, ARLEN, ARVALID, RREADY, BUSY, DONE, RD_ERR
   );
endinterface
`default_nettype wire

// File: rtl/disp_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | disp_fetch_ctrl : AXI4 read-master frame fetch engine with FIFO-credit     |
// |                   throttling; optional RRESP checking via                  |
// |                   DISP_FETCH_RRESP_CHK_EN                                  |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module disp_fetch_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int BURST_LEN  = 16,
   parameter int H_BURSTS   = 32,
   parameter int V_LINES    = 768,
   parameter int FIFO_DEPTH = 512,
   parameter int MAX_OUTST  = 4
) (
   input  logic       ACLK,
   input  logic       ARST,
   disp_fetch_if.master bus
);
   localparam int C_BURST_BYTES = BURST_LEN * DATA_W / 8;
   localparam int C_INF_W       = $clog2(MAX_OUTST * BURST_LEN + 1);
   localparam int C_OUT_W       = $clog2(MAX_OUTST + 1);
   localparam int C_BX_W        = (H_BURSTS > 1) ? $clog2(H_BURSTS) : 1;
   localparam int C_LY_W        = (V_LINES > 1) ? $clog2(V_LINES) : 1;

   localparam logic [C_BX_W-1:0] C_BX_LAST = C_BX_W'(H_BURSTS - 1);
   localparam logic [C_LY_W-1:0] C_LY_LAST = C_LY_W'(V_LINES - 1);

   localparam logic [1:0] C_S_IDLE  = 2'd0;
   localparam logic [1:0] C_S_ISSUE = 2'd1;
   localparam logic [1:0] C_S_DRAIN = 2'd2;

   logic [1:0]         r_state;
   logic               r_arvalid;
   logic [ADDR_W-1:0]  r_araddr;
   logic               r_rready;
   logic               r_busy;
   logic               r_done;
   logic               r_aborted;
   logic [C_INF_W-1:0] r_inflight;
   logic [C_OUT_W-1:0] r_outst;
   logic [C_BX_W-1:0]  r_bx;
   logic [C_LY_W-1:0]  r_ly;
   logic [ADDR_W-1:0]  r_line;
   logic [15:0]        r_pitch;

   logic               w_acc;
   logic               w_beat;
   logic               w_rlast;
   logic               w_bx_wrap;
   logic               w_last_burst;
   logic [C_INF_W-1:0] w_inflight_n;
   logic [C_OUT_W-1:0] w_outst_n;
   logic [C_BX_W-1:0]  w_bx_n;
   logic [C_LY_W-1:0]  w_ly_n;
   logic [ADDR_W-1:0]  w_line_n;
   logic [ADDR_W-1:0]  w_addr_n;
   logic [31:0]        w_need;
   logic               w_credit;
   logic               w_issue;
   logic               w_rd_err;

   assign w_acc        = r_arvalid & bus.ARREADY;
   // Beats of bursts issued before a reset arrive with zero counters and are dropped.
   assign w_beat       = bus.RVALID & r_rready & (r_inflight != '0);
   assign w_rlast      = bus.RVALID & r_rready & bus.RLAST & (r_outst != '0);
   assign w_bx_wrap    = (r_bx == C_BX_LAST);
   assign w_last_burst = w_bx_wrap & (r_ly == C_LY_LAST);

   always_comb begin
      w_inflight_n = r_inflight;
      w_outst_n    = r_outst;
      if (w_acc) begin
         w_inflight_n = w_inflight_n + C_INF_W'(BURST_LEN);
         w_outst_n    = w_outst_n + C_OUT_W'(1);
      end
      if (w_beat) begin
         w_inflight_n = w_inflight_n - C_INF_W'(1);
      end
      if (w_rlast) begin
         w_outst_n = w_outst_n - C_OUT_W'(1);
      end
   end

   // Burst pointer as it will stand after this cycle's handshake, so a
   // back-to-back request carries the following burst's address.
   always_comb begin
      w_bx_n   = r_bx;
      w_ly_n   = r_ly;
      w_line_n = r_line;
      if (w_acc) begin
         if (w_bx_wrap) begin
            w_bx_n   = '0;
            w_ly_n   = r_ly + C_LY_W'(1);
            w_line_n = r_line + ADDR_W'(r_pitch);
         end else begin
            w_bx_n = r_bx + C_BX_W'(1);
         end
      end
   end

   assign w_addr_n = w_line_n + ADDR_W'(32'(w_bx_n) * 32'(C_BURST_BYTES));
   assign w_need   = 32'(bus.FIFO_LEVEL) + 32'(w_inflight_n) + 32'(BURST_LEN);
   assign w_credit = (w_need <= 32'(FIFO_DEPTH)) && (32'(w_outst_n) < 32'(MAX_OUTST));
   assign w_issue  = (r_state == C_S_ISSUE) && bus.DISPON && (!r_arvalid || w_acc)
                     && !(w_acc && w_last_burst) && w_credit;

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         r_state    <= C_S_IDLE;
         r_arvalid  <= 1'b0;
         r_araddr   <= '0;
         r_rready   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;
         r_inflight <= '0;
         r_outst    <= '0;
         r_bx       <= '0;
         r_ly       <= '0;
         r_line     <= '0;
         r_pitch    <= '0;
      end else begin
         r_rready   <= 1'b1;
         r_done     <= 1'b0;
         r_inflight <= w_inflight_n;
         r_outst    <= w_outst_n;
         r_bx       <= w_bx_n;
         r_ly       <= w_ly_n;
         r_line     <= w_line_n;
         case (r_state)
            C_S_IDLE: begin
               if (bus.FSTART && bus.DISPON && !w_rd_err) begin
                  r_state   <= C_S_ISSUE;
                  r_line    <= bus.DISPADDR;
                  r_pitch   <= bus.STRIDE;
                  r_bx      <= '0;
                  r_ly      <= '0;
                  r_busy    <= 1'b1;
                  r_aborted <= 1'b0;
               end
            end
            C_S_ISSUE: begin
               if (w_issue) begin
                  r_arvalid <= 1'b1;
                  r_araddr  <= w_addr_n;
               end else if (w_acc) begin
                  r_arvalid <= 1'b0;
               end
               if (!bus.DISPON) begin
                  r_aborted <= 1'b1;
               end
               // A request already on the bus must complete before leaving ISSUE.
               if (w_acc && w_last_burst) begin
                  r_state <= C_S_DRAIN;
               end else if (!bus.DISPON && (!r_arvalid || w_acc)) begin
                  r_state <= C_S_DRAIN;
               end
            end
            C_S_DRAIN: begin
               if (r_outst == '0) begin
                  r_state <= C_S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= !r_aborted;
               end
            end
            default: begin
               r_state <= C_S_IDLE;
            end
         endcase
      end
   end

`ifdef DISP_FETCH_RRESP_CHK_EN
   logic r_rd_err;
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         r_rd_err <= 1'b0;
      end else if (bus.RVALID && (bus.RRESP != 2'b00)) begin
         r_rd_err <= 1'b1;
      end
   end
   assign w_rd_err = r_rd_err;
`else
   assign w_rd_err = 1'b0;
`endif

   assign bus.ARADDR  = r_araddr;
   assign bus.ARLEN   = 8'(BURST_LEN - 1);
   assign bus.ARVALID = r_arvalid;
   assign bus.RREADY  = r_rready;
   assign bus.BUSY    = r_busy;
   assign bus.DONE    = r_done;
   assign bus.RD_ERR  = w_rd_err;
endmodule
`default_nettype wire

// File: tb/tb_disp_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_disp_fetch_ctrl : directed bench for disp_fetch_ctrl with a small AXI   |
// |                      read-slave model                                      |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_disp_fetch_ctrl;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int BL     = 4;
   localparam int HB     = 2;
   localparam int VL     = 4;
   localparam int DEPTH  = 512;
   localparam int MAXO   = 4;
   localparam int NBURST = HB * VL;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   disp_fetch_if #(.ADDR_W(ADDR_W)) bus ();

   disp_fetch_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .H_BURSTS(HB),
      .V_LINES(VL), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO)
   ) dut (
      .ACLK(clk),
      .ARST(rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   // slave controls (written by the main sequence)
   int ar_allow = 1000;
   bit r_en     = 1'b0;
   int r_delay  = 0;
   int err_beat = -1;

   // monitor state
   int acc_total, rbeats, rlasts, done_cnt, peak_out, acc_at_first_rlast, beats_at_done;
   logic [ADDR_W-1:0] ar_log [16];

   assign bus.ARREADY = (acc_total < ar_allow);

   always @(posedge clk) begin
      if (rst) begin
         acc_total <= 0; rbeats <= 0; rlasts <= 0; done_cnt <= 0;
         peak_out <= 0; acc_at_first_rlast <= -1; beats_at_done <= -1;
      end else begin
         if (bus.ARVALID && bus.ARREADY) begin
            ar_log[acc_total[3:0]] <= bus.ARADDR;
            acc_total <= acc_total + 1;
         end
         if (bus.RVALID) rbeats <= rbeats + 1;
         if (bus.RVALID && bus.RLAST) begin
            rlasts <= rlasts + 1;
            if (rlasts == 0) acc_at_first_rlast <= acc_total;
         end
         if (bus.DONE) begin
            done_cnt      <= done_cnt + 1;
            beats_at_done <= rbeats;
         end
         if (acc_total - rlasts > peak_out) peak_out <= acc_total - rlasts;
      end
   end

   // R channel: each accepted burst is answered with BL beats after r_delay idle cycles
   int sent_bursts, beat_idx, wait_c, beat_total;
   initial begin
      bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
      sent_bursts = 0; beat_idx = 0; wait_c = 0; beat_total = 0;
      forever begin
         @(posedge clk);
         #1;
         bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.RRESP = 2'b00;
         if (rst) begin
            sent_bursts = 0; beat_idx = 0; wait_c = 0; beat_total = 0;
         end else if (r_en && (acc_total > sent_bursts)) begin
            if (wait_c < r_delay) begin
               wait_c++;
            end else begin
               bus.RVALID = 1'b1;
               bus.RRESP  = (beat_total == err_beat) ? 2'b10 : 2'b00;
               bus.RLAST  = (beat_idx == BL - 1);
               beat_total++;
               if (beat_idx == BL - 1) begin
                  beat_idx = 0; wait_c = 0; sent_bursts++;
               end else begin
                  beat_idx++;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.DISPON = 1'b0; bus.FSTART = 1'b0;
      r_en = 1'b0; r_delay = 0; err_beat = -1; ar_allow = 1000;
      cyc(2);
   endtask

   task automatic end_reset(input logic [9:0] level);
      rst = 1'b0;
      bus.FIFO_LEVEL = level;
      bus.DISPADDR   = 32'h1000_0000;
      bus.STRIDE     = 16'h0100;
      bus.DISPON     = 1'b1;
      cyc(2);
   endtask

   task automatic pulse_fstart();
      @(negedge clk) bus.FSTART = 1'b1;
      @(negedge clk) bus.FSTART = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
   endtask

   typedef struct {
      logic [9:0] level;
      int         exp_ars;
   } cred_vec_t;

   cred_vec_t   vecs [6];
   logic [31:0] exp_addr [NBURST];

   initial begin
      bus.FSTART = 1'b0; bus.DISPON = 1'b0; bus.FIFO_LEVEL = '0;
      bus.DISPADDR = '0; bus.STRIDE = '0;

      vecs[0] = '{10'(DEPTH - BL + 1),     0};
      vecs[1] = '{10'(DEPTH - BL),         1};
      vecs[2] = '{10'(DEPTH - 2 * BL + 1), 1};
      vecs[3] = '{10'(DEPTH - 2 * BL),     2};
      vecs[4] = '{10'(DEPTH - 3 * BL),     3};
      vecs[5] = '{10'd0,                   MAXO};

      exp_addr[0] = 32'h1000_0000; exp_addr[1] = 32'h1000_0020;
      exp_addr[2] = 32'h1000_0100; exp_addr[3] = 32'h1000_0120;
      exp_addr[4] = 32'h1000_0200; exp_addr[5] = 32'h1000_0220;
      exp_addr[6] = 32'h1000_0300; exp_addr[7] = 32'h1000_0320;

      // reset values while ARST is held
      start_reset();
      check("reset_outputs",
            64'({bus.ARVALID, bus.ARADDR, bus.RREADY, bus.BUSY, bus.DONE, bus.RD_ERR}), 64'd0);
      end_reset(10'd0);
      check("rready_after_reset", 64'(bus.RREADY), 64'd1);

      // credit table: R channel held off, count issued bursts
      for (int i = 0; i < 6; i++) begin
         start_reset();
         end_reset(vecs[i].level);
         pulse_fstart();
         cyc(20);
         check($sformatf("credit_level_%0d", vecs[i].level), 64'(acc_total), 64'(vecs[i].exp_ars));
      end

      // full frame, always-ready slave, with an ignored mid-frame FSTART
      start_reset();
      end_reset(10'd0);
      r_en = 1'b1;
      pulse_fstart();
      check("busy_after_fstart", 64'(bus.BUSY), 64'd1);
      cyc(3);
      pulse_fstart();
      wait_done("frame_done_timeout", 500);
      cyc(5);
      check("frame_done_count", 64'(done_cnt), 64'd1);
      check("frame_ar_count", 64'(acc_total), 64'(NBURST));
      for (int i = 0; i < NBURST; i++)
         check($sformatf("araddr_%0d", i), 64'(ar_log[i]), 64'(exp_addr[i]));
      check("beats_at_done", 64'(beats_at_done), 64'(NBURST * BL));
      check("busy_after_done", 64'(bus.BUSY), 64'd0);
      check("arlen", 64'(bus.ARLEN), 64'(BL - 1));

      // one burst fits, the next only after its beats drain
      start_reset();
      end_reset(10'(DEPTH - BL));
      pulse_fstart();
      cyc(20);
      check("stall_single_ar", 64'(acc_total), 64'd1);
      r_en = 1'b1;
      for (int n = 0; n < 40 && acc_total < 2; n++) @(negedge clk);
      check("stall_resume_ar", 64'(acc_total), 64'd2);

      // slow slave: outstanding limit
      start_reset();
      end_reset(10'd0);
      r_en = 1'b1; r_delay = 50;
      pulse_fstart();
      wait_done("slow_done_timeout", 1500);
      check("outst_peak", 64'(peak_out), 64'(MAXO));
      check("ars_before_first_rlast", 64'(acc_at_first_rlast), 64'(MAXO));

      // ARREADY held low: request must stay stable
      start_reset();
      end_reset(10'd0);
      ar_allow = 0; r_en = 1'b1;
      pulse_fstart();
      begin
         int n = 0;
         int stable = 0;
         logic [ADDR_W-1:0] cap;
         while (!bus.ARVALID && n < 20) begin
            @(negedge clk);
            n++;
         end
         cap = bus.ARADDR;
         check("hold_first_addr", 64'(cap), 64'h1000_0000);
         for (int i = 0; i < 10; i++) begin
            if (bus.ARVALID && bus.ARADDR == cap) stable++;
            @(negedge clk);
         end
         check("hold_stable_cycles", 64'(stable), 64'd10);
         ar_allow = 1;
         @(negedge clk);
         check("hold_accepted", 64'(acc_total), 64'd1);
      end

      // display disabled after three bursts: abort without DONE
      start_reset();
      end_reset(10'(DEPTH - 3 * BL));
      pulse_fstart();
      cyc(20);
      bus.DISPON = 1'b0;
      cyc(3);
      r_en = 1'b1;
      for (int n = 0; n < 100 && bus.BUSY; n++) @(negedge clk);
      check("abort_busy_clear", 64'(bus.BUSY), 64'd0);
      check("abort_rlasts", 64'(rlasts), 64'd3);
      cyc(5);
      check("abort_ar_count", 64'(acc_total), 64'd3);
      check("abort_no_done", 64'(done_cnt), 64'd0);

      // error response on one beat
      start_reset();
      end_reset(10'd0);
      r_en = 1'b1; err_beat = 5;
      pulse_fstart();
      wait_done("err_done_timeout", 500);
      cyc(2);
      check("err_done_count", 64'(done_cnt), 64'd1);
`ifdef DISP_FETCH_RRESP_CHK_EN
      check("rd_err_flag", 64'(bus.RD_ERR), 64'd1);
      pulse_fstart();
      cyc(2);
      check("fstart_after_err", 64'(bus.BUSY), 64'd0);
`else
      check("rd_err_flag", 64'(bus.RD_ERR), 64'd0);
      pulse_fstart();
      cyc(2);
      check("fstart_after_err", 64'(bus.BUSY), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
`default_nettype wire
